// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - round/op sequencing FSM for the iterative AES core (enc/dec, AES-128/192/256)
module aes_round_sequencer #(
  parameter int NR            = 10,
  parameter int MC_COLS       = 1,
  parameter int KEYEXP_CYCLES = 11
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       MODE,
  input  logic       ABORT,
  output logic       BUSY,
  output logic       DONE,
  output logic       mode_q,
  output logic [1:0] op_sel,
  output logic [1:0] col_sel,
  output logic [3:0] key_idx,
  output logic       ld_state,
  output logic       ld_msg
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_round_sequencer: NR must be 10, 12 or 14");
  end
  if (!(MC_COLS == 1 || MC_COLS == 2 || MC_COLS == 4)) begin : g_bad_mc
    $error("aes_round_sequencer: MC_COLS must be 1, 2 or 4");
  end
  if (KEYEXP_CYCLES < 1 || KEYEXP_CYCLES > 31) begin : g_bad_kx
    $error("aes_round_sequencer: KEYEXP_CYCLES must be in 1..31");
  end

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_KEYEXP = 3'd1;
  localparam logic [2:0] S_ARK0   = 3'd2;
  localparam logic [2:0] S_SB     = 3'd3;
  localparam logic [2:0] S_SR     = 3'd4;
  localparam logic [2:0] S_MC     = 3'd5;
  localparam logic [2:0] S_ARK    = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [3:0] NR_K        = 4'(NR);
  localparam logic [3:0] LAST_RND    = 4'(NR - 1);
  localparam logic [1:0] LAST_BEAT   = 2'((4 / MC_COLS) - 1);
  localparam logic [4:0] KEYEXP_LAST = 5'(KEYEXP_CYCLES - 1);

  logic [2:0] state;
  logic [3:0] rnd;
  logic [1:0] beat;
  logic [4:0] kcnt;
  logic       fin;       // set once the final (no mix-columns) round is entered
  logic       busy_int;
  logic       op_state;
  logic [1:0] col_base;

  assign busy_int = (state != S_IDLE) && (state != S_DONE);
  assign op_state = (state == S_ARK0) || (state == S_SB) || (state == S_SR) ||
                    (state == S_MC)   || (state == S_ARK);

  always_comb begin
    col_base = 2'b00;
    if (MC_COLS == 1)      col_base = beat;
    else if (MC_COLS == 2) col_base = {beat[0], 1'b0};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_IDLE;
      rnd    <= '0;
      beat   <= '0;
      kcnt   <= '0;
      fin    <= 1'b0;
      mode_q <= 1'b0;
    end else if (ABORT && busy_int) begin
      state <= S_IDLE;
      rnd   <= '0;
      beat  <= '0;
      kcnt  <= '0;
      fin   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            state  <= S_KEYEXP;
            mode_q <= MODE;
            kcnt   <= '0;
            rnd    <= '0;
            fin    <= 1'b0;
          end
        end
        S_KEYEXP: begin
          if (kcnt == KEYEXP_LAST) begin
            state <= S_ARK0;
            kcnt  <= '0;
          end else begin
            kcnt <= kcnt + 5'd1;
          end
        end
        S_ARK0: begin
          rnd   <= 4'd1;
          state <= mode_q ? S_SB : S_SR;
        end
        S_SB: state <= mode_q ? S_SR : S_ARK;
        S_SR: begin
          if (mode_q) state <= fin ? S_ARK : S_MC;
          else        state <= S_SB;
        end
        S_MC: begin
          if (beat == LAST_BEAT) begin
            beat <= '0;
            if (mode_q) begin
              state <= S_ARK;
            end else begin
              state <= S_SR;
              if (rnd == LAST_RND) fin <= 1'b1;
              else                 rnd <= rnd + 4'd1;
            end
          end else begin
            beat <= beat + 2'd1;
          end
        end
        S_ARK: begin
          if (fin) begin
            state <= S_DONE;
          end else if (mode_q) begin
            state <= S_SB;
            if (rnd == LAST_RND) fin <= 1'b1;
            else                 rnd <= rnd + 4'd1;
          end else begin
            state <= S_MC;
          end
        end
        S_DONE: begin
          if (!START) begin
            state <= S_IDLE;
            rnd   <= '0;
            fin   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // An aborting cycle must not disturb the state register, so the strobe is gated by ABORT.
  always_comb begin
    BUSY     = busy_int;
    DONE     = (state == S_DONE);
    ld_state = op_state && !ABORT;
    ld_msg   = 1'b0;
    op_sel   = 2'b00;
    col_sel  = 2'b00;
    key_idx  = 4'd0;
    if (ld_state) begin
      case (state)
        S_ARK0: begin
          ld_msg  = 1'b1;
          key_idx = mode_q ? 4'd0 : NR_K;
        end
        S_SB: op_sel = 2'b10;
        S_SR: op_sel = 2'b01;
        S_MC: begin
          op_sel  = 2'b11;
          col_sel = col_base;
        end
        S_ARK: begin
          if (fin) key_idx = mode_q ? NR_K : 4'd0;
          else     key_idx = mode_q ? rnd : (NR_K - rnd);
        end
        default: op_sel = 2'b00;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - self-checking bench for aes_round_sequencer across three configurations
module tb_aes_round_sequencer;

  localparam int NO_ABORT = 9999;

  logic       clk = 1'b0;
  logic       reset;
  logic       start [3];
  logic       mode  [3];
  logic       abort [3];
  logic       busy  [3];
  logic       done  [3];
  logic       mode_q[3];
  logic       ld_state[3];
  logic       ld_msg[3];
  logic [1:0] op_sel[3];
  logic [1:0] col_sel[3];
  logic [3:0] key_idx[3];

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic       msg;
    logic [1:0] op;
    logic [1:0] col;
    logic [3:0] key;
  } beat_t;
  beat_t exp_q[$];

  typedef struct {
    int         inst;
    bit         enc;
    int         lat;
    logic [3:0] ark0_key;
    logic [3:0] fin_key;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  aes_round_sequencer #(.NR(10), .MC_COLS(1), .KEYEXP_CYCLES(11)) u0 (
    .CLK(clk), .RESET(reset), .START(start[0]), .MODE(mode[0]), .ABORT(abort[0]),
    .BUSY(busy[0]), .DONE(done[0]), .mode_q(mode_q[0]), .op_sel(op_sel[0]),
    .col_sel(col_sel[0]), .key_idx(key_idx[0]), .ld_state(ld_state[0]), .ld_msg(ld_msg[0]));

  aes_round_sequencer #(.NR(14), .MC_COLS(4), .KEYEXP_CYCLES(11)) u1 (
    .CLK(clk), .RESET(reset), .START(start[1]), .MODE(mode[1]), .ABORT(abort[1]),
    .BUSY(busy[1]), .DONE(done[1]), .mode_q(mode_q[1]), .op_sel(op_sel[1]),
    .col_sel(col_sel[1]), .key_idx(key_idx[1]), .ld_state(ld_state[1]), .ld_msg(ld_msg[1]));

  aes_round_sequencer #(.NR(12), .MC_COLS(2), .KEYEXP_CYCLES(3)) u2 (
    .CLK(clk), .RESET(reset), .START(start[2]), .MODE(mode[2]), .ABORT(abort[2]),
    .BUSY(busy[2]), .DONE(done[2]), .mode_q(mode_q[2]), .op_sel(op_sel[2]),
    .col_sel(col_sel[2]), .key_idx(key_idx[2]), .ld_state(ld_state[2]), .ld_msg(ld_msg[2]));

  function automatic int nr_of(input int i);
    return (i == 0) ? 10 : (i == 1) ? 14 : 12;
  endfunction
  function automatic int mc_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : 2;
  endfunction
  function automatic int kx_of(input int i);
    return (i == 2) ? 3 : 11;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic push(input int m, input int op, input int col, input int key);
    exp_q.push_back('{msg: 1'(m), op: 2'(op), col: 2'(col), key: 4'(key)});
  endtask

  task automatic push_mc(input int mc);
    for (int b = 0; b < 4 / mc; b++) push(0, 3, b * mc, 0);
  endtask

  // Reference sequence of datapath operations, one entry per ld_state cycle.
  task automatic build(input int nr, input int mc, input bit enc);
    exp_q.delete();
    push(1, 0, 0, enc ? 0 : nr);
    for (int r = 1; r < nr; r++) begin
      if (enc) begin
        push(0, 2, 0, 0); push(0, 1, 0, 0); push_mc(mc); push(0, 0, 0, r);
      end else begin
        push(0, 1, 0, 0); push(0, 2, 0, 0); push(0, 0, 0, nr - r); push_mc(mc);
      end
    end
    if (enc) begin push(0, 2, 0, 0); push(0, 1, 0, 0); push(0, 0, 0, nr); end
    else     begin push(0, 1, 0, 0); push(0, 2, 0, 0); push(0, 0, 0, 0); end
  endtask

  task automatic chk_idle(input int i, input string tag);
    chk({tag, "_busy"}, 32'(busy[i]), 0);
    chk({tag, "_done"}, 32'(done[i]), 0);
    chk({tag, "_ld_state"}, 32'(ld_state[i]), 0);
    chk({tag, "_ld_msg"}, 32'(ld_msg[i]), 0);
    chk({tag, "_op_sel"}, 32'(op_sel[i]), 0);
    chk({tag, "_col_sel"}, 32'(col_sel[i]), 0);
    chk({tag, "_key_idx"}, 32'(key_idx[i]), 0);
  endtask

  // Starts an operation on instance i (inputs applied #1 after an edge) and follows it cycle by cycle.
  task automatic run_op(input int i, input bit enc, input int abort_at, input bit rand_mode,
                        output int lat, output logic [3:0] k0, output logic [3:0] kf);
    int nr = nr_of(i);
    int k  = kx_of(i);
    int len;
    build(nr, mc_of(i), enc);
    len = exp_q.size();
    lat = -1;
    k0  = 4'hx;
    kf  = 4'hx;
    start[i] = 1'b1;
    mode[i]  = enc;
    @(posedge clk); #1;
    for (int c = 0; c <= k + len; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (rand_mode) mode[i] = 1'($urandom_range(0, 1));
      if (done[i] && lat < 0) lat = c;
      chk("mode_q", 32'(mode_q[i]), 32'(enc));
      if (c == k + abort_at) begin
        abort[i] = 1'b1;
        start[i] = 1'b0;
        #1;
        chk("abort_cycle_ld_state", 32'(ld_state[i]), 0);
        chk("abort_cycle_op_sel", 32'(op_sel[i]), 0);
        chk("abort_cycle_busy", 32'(busy[i]), 1);
        @(posedge clk); #1;
        abort[i] = 1'b0;
        chk_idle(i, "after_abort");
        for (int w = 0; w < 4; w++) begin
          @(posedge clk); #1;
          chk("abort_done_low", 32'(done[i]), 0);
          chk("abort_busy_low", 32'(busy[i]), 0);
        end
        return;
      end
      if (c < k) begin
        chk("keyexp_busy", 32'(busy[i]), 1);
        chk("keyexp_done", 32'(done[i]), 0);
        chk("keyexp_ld_state", 32'(ld_state[i]), 0);
        chk("keyexp_key_idx", 32'(key_idx[i]), 0);
      end else if (c < k + len) begin
        beat_t e = exp_q[c - k];
        if (c == k) k0 = key_idx[i];
        if (c == k + len - 1) kf = key_idx[i];
        chk("op_busy", 32'(busy[i]), 1);
        chk("op_done", 32'(done[i]), 0);
        chk("ld_state", 32'(ld_state[i]), 1);
        chk("ld_msg", 32'(ld_msg[i]), 32'(e.msg));
        chk("op_sel", 32'(op_sel[i]), 32'(e.op));
        chk("col_sel", 32'(col_sel[i]), 32'(e.col));
        chk("key_idx", 32'(key_idx[i]), 32'(e.key));
      end else begin
        chk("done_high", 32'(done[i]), 1);
        chk("done_busy", 32'(busy[i]), 0);
        chk("done_ld_state", 32'(ld_state[i]), 0);
      end
    end
    // START held: DONE persists and ABORT has no effect here.
    for (int h = 0; h < 10; h++) begin
      abort[i] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("done_hold", 32'(done[i]), 1);
      chk("done_hold_busy", 32'(busy[i]), 0);
    end
    abort[i] = 1'b0;
    start[i] = 1'b0;
    @(posedge clk); #1;
    chk_idle(i, "after_done");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [3:0] k0, kf;

    tbl[0] = '{inst: 0, enc: 1'b0, lat: 78, ark0_key: 4'd10, fin_key: 4'd0};
    tbl[1] = '{inst: 0, enc: 1'b1, lat: 78, ark0_key: 4'd0,  fin_key: 4'd10};
    tbl[2] = '{inst: 1, enc: 1'b1, lat: 67, ark0_key: 4'd0,  fin_key: 4'd14};
    tbl[3] = '{inst: 1, enc: 1'b0, lat: 67, ark0_key: 4'd14, fin_key: 4'd0};
    tbl[4] = '{inst: 2, enc: 1'b0, lat: 62, ark0_key: 4'd12, fin_key: 4'd0};
    tbl[5] = '{inst: 2, enc: 1'b1, lat: 62, ark0_key: 4'd0,  fin_key: 4'd12};

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; mode[i] = 1'b0; abort[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_idle(i, "reset");
      chk("reset_mode_q", 32'(mode_q[i]), 0);
    end

    // ABORT while idle is ignored.
    abort[0] = 1'b1;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    chk_idle(0, "abort_in_idle");

    foreach (tbl[t]) begin
      run_op(tbl[t].inst, tbl[t].enc, NO_ABORT, 1'b0, lat, k0, kf);
      chk("tbl_latency", 32'(lat), 32'(tbl[t].lat));
      chk("tbl_ark0_key", 32'(k0), 32'(tbl[t].ark0_key));
      chk("tbl_final_key", 32'(kf), 32'(tbl[t].fin_key));
    end

    // ABORT in the second mix-columns beat of round 5 (decrypt, one column per beat), then a full rerun.
    run_op(0, 1'b0, 1 + 4 * 7 + 3 + 1, 1'b0, lat, k0, kf);
    chk("abort_no_done", 32'(lat), 32'hffff_ffff);
    run_op(0, 1'b0, NO_ABORT, 1'b0, lat, k0, kf);
    chk("rerun_latency", 32'(lat), 78);

    // RESET in KEYEXP, then a new operation with a different mode.
    start[0] = 1'b1; mode[0] = 1'b0;
    @(posedge clk); #1;
    mode[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_busy", 32'(busy[0]), 1);
    reset = 1'b1; start[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_idle(0, "mid_reset");
    chk("mid_reset_mode_q", 32'(mode_q[0]), 0);
    @(posedge clk); #1;
    chk("post_reset_busy", 32'(busy[0]), 0);
    run_op(0, 1'b1, NO_ABORT, 1'b1, lat, k0, kf);
    chk("post_reset_latency", 32'(lat), 78);

    // Random runs with MODE wandering mid-operation and optional ABORT anywhere in KEYEXP or the op sequence.
    for (int n = 0; n < 8; n++) begin
      int i    = int'($urandom_range(0, 2));
      bit enc  = 1'($urandom_range(0, 1));
      int len  = 1 + (nr_of(i) - 1) * (3 + 4 / mc_of(i)) + 3;
      int ab   = ($urandom_range(0, 1) == 1) ?
                 int'($urandom_range(0, len + kx_of(i) - 1)) - kx_of(i) : NO_ABORT;
      run_op(i, enc, ab, 1'b1, lat, k0, kf);
      if (ab == NO_ABORT) chk("rand_latency", 32'(lat), 32'(kx_of(i) + len));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
